// File: rtl/booth_seq_mul_if.sv
// Start/done handshake bundle shared by the sequential multiply/divide datapaths.
// The master issues start with operands; the slave reports busy, done and the held product.
interface booth_seq_mul_if #(
  parameter int WM = 5,
  parameter int WQ = 4
);
  logic              start;
  logic [WM-1:0]     multiplicand;
  logic [WQ-1:0]     multiplier;
  logic              busy;
  logic              done;
  logic [WM+WQ-1:0]  product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, signed x signed.
// Optional macro BOOTH_MUL_ZERO_SKIP_EN: a zero operand completes in one clock from IDLE.
module booth_seq_mul #(
  parameter int WM = 5,
  parameter int WQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_mul_if.slave  bus,
  output logic            dbg_state
);

  // Handshake: start is sampled only on an edge where busy=0; done is a one-cycle
  // pulse announcing a new product, which is held until the following done.
  localparam int CW = (WQ > 1) ? $clog2(WQ) : 1;
  localparam int TW = WM + 1 + WQ + 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t            state;
  logic [WM-1:0]     m_reg;
  logic [WM:0]       a_reg;
  logic [WQ-1:0]     q_reg;
  logic              q_1;
  logic [CW-1:0]     count;
  logic              busy_r;
  logic              done_r;
  logic [WM+WQ-1:0]  product_r;

  logic [WM:0]       m_sxt;
  logic [WM:0]       a_sum;
  logic [TW-1:0]     acc;
  logic [TW-1:0]     shifted;
  logic              zero_op;

  assign m_sxt = {m_reg[WM-1], m_reg};

  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], q_1})
      2'b10:   a_sum = a_reg - m_sxt;
      2'b01:   a_sum = a_reg + m_sxt;
      default: a_sum = a_reg;
    endcase
  end

  // A carries one guard bit, so the arithmetic shift of {A,Q,q_1} stays exact.
  assign acc     = {a_sum, q_reg, q_1};
  assign shifted = $signed(acc) >>> 1;

`ifdef BOOTH_MUL_ZERO_SKIP_EN
  assign zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_reg     <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      q_1       <= 1'b0;
      count     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (zero_op) begin
              product_r <= '0;
              done_r    <= 1'b1;
            end else begin
              m_reg  <= bus.multiplicand;
              a_reg  <= '0;
              q_reg  <= bus.multiplier;
              q_1    <= 1'b0;
              count  <= '0;
              busy_r <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          a_reg <= shifted[TW-1 -: WM+1];
          q_reg <= shifted[WQ:1];
          q_1   <= shifted[0];
          count <= count + 1'b1;
          if (count == CW'(WQ - 1)) begin
            product_r <= shifted[WM+WQ:1];
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
  assign dbg_state   = (state == CALC);

endmodule
